// File: rtl/alu_seq.sv
// alu_seq: start/done handshaked ALU for the SAP datapath (add/sub/carry/logic/shift/rotate).
// Define ALU_SEQ_MULDIV_EN to compile in the multi-cycle shift-add MUL and restoring DIV.
module alu_seq #(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                clk_en,
    input  logic                i_start,
    input  logic [OP_WIDTH-1:0] i_op,
    input  logic                i_latch_flags,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_t,
    output logic                o_busy,
    output logic                o_done,
    output logic [WIDTH-1:0]    o_data,
    output logic [WIDTH-1:0]    o_data_hi,
    output logic                o_zero,
    output logic                o_carry,
    output logic                o_odd,
    output logic                o_neg,
    output logic                o_ovf
);

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ADC = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SBC = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SL  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SR  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_ROL = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_ROR = OP_WIDTH'(10);
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(12);
    localparam int                  CNT_W  = $clog2(WIDTH);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_c;
    logic             sc_v;
    logic             sc_legal;
    logic             sc_multi;
    logic             carry_in;

    assign carry_in = o_carry & ((i_op == OP_ADC) | (i_op == OP_SBC));

    // Single-cycle result; carry-chained ops use the flag as it stands at accept.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        sum_ext  = '0;
        sc_lo    = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_legal = 1'b1;
        sc_multi = 1'b0;
        case (i_op)
            OP_ADD, OP_ADC: begin
                sum_ext = {1'b0, i_a} + {1'b0, i_t} + {{WIDTH{1'b0}}, carry_in};
                sc_lo   = sum_ext[WIDTH-1:0];
                sc_c    = sum_ext[WIDTH];
                sc_v    = (i_a[WIDTH-1] == i_t[WIDTH-1]) && (sum_ext[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                sum_ext = {1'b0, i_a} - {1'b0, i_t} - {{WIDTH{1'b0}}, carry_in};
                sc_lo   = sum_ext[WIDTH-1:0];
                sc_c    = sum_ext[WIDTH];
                sc_v    = (i_a[WIDTH-1] != i_t[WIDTH-1]) && (sum_ext[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: sc_lo = i_a & i_t;
            OP_OR:  sc_lo = i_a | i_t;
            OP_XOR: sc_lo = i_a ^ i_t;
            OP_SL: begin
                sc_lo = {i_a[WIDTH-2:0], 1'b0};
                sc_c  = i_a[WIDTH-1];
            end
            OP_SR: begin
                sc_lo = {1'b0, i_a[WIDTH-1:1]};
                sc_c  = i_a[0];
            end
            OP_ROL: begin
                sc_lo = {i_a[WIDTH-2:0], o_carry};
                sc_c  = i_a[WIDTH-1];
            end
            OP_ROR: begin
                sc_lo = {o_carry, i_a[WIDTH-1:1]};
                sc_c  = i_a[0];
            end
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_DIV: begin
                sc_multi = 1'b1;
                sc_legal = 1'b0;
            end
`endif
            default: sc_legal = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // work holds {hi, lo} for MUL and {remainder, quotient} for DIV; opnd is the
    // multiplicand or divisor.
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] work_next;
    logic [WIDTH-1:0]   opnd;
    logic [CNT_W-1:0]   cnt;
    logic               run_div;
    logic               run_latch;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (run_div) begin
            if (div_shift >= {1'b0, opnd}) begin
                work_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            end else begin
                work_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
            end
        end else begin
            work_next = {mul_sum, work[WIDTH-1:1]};
        end
    end
`else
    assign o_busy = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments only, so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            o_done    <= 1'b0;
            o_data    <= '0;
            o_data_hi <= '0;
            o_zero    <= 1'b0;
            o_carry   <= 1'b0;
            o_odd     <= 1'b0;
            o_neg     <= 1'b0;
            o_ovf     <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            o_busy    <= 1'b0;
            work      <= '0;
            opnd      <= '0;
            cnt       <= '0;
            run_div   <= 1'b0;
            run_latch <= 1'b0;
`endif
        end else if (clk_en) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start && !sc_multi) begin
                        state     <= S_DONE;
                        o_done    <= 1'b1;
                        o_data    <= sc_lo;
                        o_data_hi <= '0;
                        if (sc_legal && i_latch_flags) begin
                            o_zero  <= (sc_lo == '0);
                            o_carry <= sc_c;
                            o_odd   <= sc_lo[0];
                            o_neg   <= sc_lo[WIDTH-1];
                            o_ovf   <= sc_v;
                        end
                    end
`ifdef ALU_SEQ_MULDIV_EN
                    else if (i_start) begin
                        state     <= S_RUN;
                        o_busy    <= 1'b1;
                        o_done    <= 1'b0;
                        cnt       <= '0;
                        run_div   <= (i_op == OP_DIV);
                        run_latch <= i_latch_flags;
                        opnd      <= (i_op == OP_DIV) ? i_t : i_a;
                        work      <= {{WIDTH{1'b0}}, (i_op == OP_DIV) ? i_a : i_t};
                    end
`endif
                    else begin
                        state  <= S_IDLE;
                        o_done <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_RUN: begin
                    work <= work_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_data    <= work_next[WIDTH-1:0];
                        o_data_hi <= work_next[2*WIDTH-1:WIDTH];
                        if (run_latch) begin
                            o_zero  <= run_div ? (work_next[WIDTH-1:0] == '0) : (work_next == '0);
                            o_carry <= run_div ? (opnd == '0) : (work_next[2*WIDTH-1:WIDTH] != '0);
                            o_odd   <= work_next[0];
                            o_neg   <= work_next[WIDTH-1];
                            o_ovf   <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): constant vector table, hand-written
// multi-cycle sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic       clk;
    logic       i_rst_n;
    logic       clk_en;
    logic       i_start;
    logic [3:0] i_op;
    logic       i_latch_flags;
    logic [7:0] i_a;
    logic [7:0] i_t;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_data;
    logic [7:0] o_data_hi;
    logic       o_zero;
    logic       o_carry;
    logic       o_odd;
    logic       o_neg;
    logic       o_ovf;

    alu_seq #(.WIDTH(8), .OP_WIDTH(4)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .clk_en       (clk_en),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_latch_flags(i_latch_flags),
        .i_a          (i_a),
        .i_t          (i_t),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_data       (o_data),
        .o_data_hi    (o_data_hi),
        .o_zero       (o_zero),
        .o_carry      (o_carry),
        .o_odd        (o_odd),
        .o_neg        (o_neg),
        .o_ovf        (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference flag state and expectations for the op in flight.
    bit         m_z, m_c, m_o, m_n, m_v;
    logic [7:0] e_lo, e_hi;
    int         e_lat, e_busy;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] t;
        bit         lf;
        logic [7:0] lo;
        logic [4:0] flags;   // {zero, carry, odd, neg, ovf}
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_op(input int op, input int a, input int t, input bit lf);
        int r, sr, sa, st, cin, lo, hi;
        bit c, v, z, legal, multi;
        sa = (a > 127) ? a - 256 : a;
        st = (t > 127) ? t - 256 : t;
        cin = m_c ? 1 : 0;
        r = 0; sr = 0; lo = 0; hi = 0;
        c = 0; v = 0; legal = 1; multi = 0;
        case (op)
            0: begin r = a + t;       sr = sa + st;       end
            1: begin r = a - t;       sr = sa - st;       end
            2: begin r = a + t + cin; sr = sa + st + cin; end
            3: begin r = a - t - cin; sr = sa - st - cin; end
            4: lo = a & t;
            5: lo = a | t;
            6: lo = a ^ t;
            7: begin lo = (a * 2) & 255;       c = (a > 127);   end
            8: begin lo = a / 2;               c = (a % 2) == 1; end
            9: begin lo = ((a * 2) & 255) + cin; c = (a > 127); end
            10: begin lo = a / 2 + cin * 128;  c = (a % 2) == 1; end
            11: if (MD) begin
                    multi = 1; r = a * t; lo = r & 255; hi = r / 256; c = (hi != 0);
                end else legal = 0;
            12: if (MD) begin
                    multi = 1;
                    if (t == 0) begin lo = 255; hi = a; c = 1; end
                    else begin lo = a / t; hi = a % t; end
                end else legal = 0;
            default: legal = 0;
        endcase
        if (op <= 3) begin
            lo = r & 255;
            c  = (r < 0) || (r > 255);
            v  = (sr < -128) || (sr > 127);
        end
        z = (op == 11) ? (r == 0) : (lo == 0);
        e_lo   = 8'(lo);
        e_hi   = 8'(hi);
        e_lat  = multi ? 9 : 1;
        e_busy = multi ? 8 : 0;
        if (legal && lf) begin
            m_z = z; m_c = c; m_o = (lo & 1) != 0; m_n = (lo & 128) != 0; m_v = v;
        end
    endtask

    // Launch one op, wait for done (bounded), compare against the model.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] t,
                         input bit lf, input bit pulse, input bit toggle, input bit hold,
                         input string tag);
        int lat, busy_n, cyc;
        bit en_was;
        model_op(int'(op), int'(a), int'(t), lf);
        clk_en = 1'b1; i_op = op; i_a = a; i_t = t; i_latch_flags = lf; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; lat = 1; busy_n = 0; cyc = 0;
        while (!o_done && cyc < 60) begin
            cyc++;
            i_start = pulse && (cyc == 3);
            if (i_start) begin i_op = 4'd0; i_a = 8'h11; i_t = 8'h22; end
            if (toggle) clk_en = (cyc % 3) != 1;
            en_was = clk_en;
            if (en_was && o_busy) busy_n++;
            @(posedge clk); #1;
            if (en_was) lat++;
        end
        i_start = 1'b0; clk_en = 1'b1;
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(e_busy));
        check({tag, " lo"}, 32'(o_data), 32'(e_lo));
        check({tag, " hi"}, 32'(o_data_hi), 32'(e_hi));
        check({tag, " flags"}, 32'({o_zero, o_carry, o_odd, o_neg, o_ovf}),
              32'({m_z, m_c, m_o, m_n, m_v}));
        if (!hold) begin
            @(posedge clk); #1;
            check({tag, " done clear"}, 32'(o_done), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 5'b00011};
        vecs[1]  = '{4'd1,  8'h00, 8'h01, 1'b1, 8'hFF, 5'b01110};
        vecs[2]  = '{4'd2,  8'h10, 8'h10, 1'b1, 8'h21, 5'b00100};
        vecs[3]  = '{4'd6,  8'h5A, 8'h5A, 1'b1, 8'h00, 5'b10000};
        vecs[4]  = '{4'd7,  8'h81, 8'h33, 1'b1, 8'h02, 5'b01000};
        vecs[5]  = '{4'd10, 8'h01, 8'h00, 1'b1, 8'h80, 5'b01010};
        vecs[6]  = '{4'd9,  8'h80, 8'h00, 1'b1, 8'h01, 5'b01100};
        vecs[7]  = '{4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 5'b01100};
        vecs[8]  = '{4'd13, 8'h12, 8'h34, 1'b1, 8'h00, 5'b01100};
        vecs[9]  = '{4'd3,  8'h80, 8'h00, 1'b1, 8'h7F, 5'b00101};
        vecs[10] = '{4'd5,  8'h00, 8'h00, 1'b1, 8'h00, 5'b10000};
        vecs[11] = '{4'd8,  8'h03, 8'h00, 1'b1, 8'h01, 5'b01100};
        vecs[12] = '{4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 5'b11000};
        vecs[13] = '{4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 5'b00101};
        vecs[14] = '{4'd2,  8'hFF, 8'h00, 1'b1, 8'hFF, 5'b00110};

        i_rst_n = 1'b0; clk_en = 1'b0; i_start = 1'b0; i_op = '0;
        i_latch_flags = 1'b0; i_a = '0; i_t = '0;
        m_z = 0; m_c = 0; m_o = 0; m_n = 0; m_v = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset lo", 32'(o_data), 32'd0);
        check("reset hi", 32'(o_data_hi), 32'd0);
        check("reset flags", 32'({o_zero, o_carry, o_odd, o_neg, o_ovf}), 32'd0);
        i_rst_n = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].t, vecs[i].lf, 1'b0, 1'b0, 1'b0,
                  $sformatf("vec%0d", i));
            check($sformatf("vec%0d table lo", i), 32'(o_data), 32'(vecs[i].lo));
            check($sformatf("vec%0d table flags", i),
                  32'({o_zero, o_carry, o_odd, o_neg, o_ovf}), 32'(vecs[i].flags));
        end

        // MUL 0xFF*0xFF with a stray start mid-run.
        do_op(4'd11, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, "mul_ff_ff");
`ifdef ALU_SEQ_MULDIV_EN
        check("mul_ff_ff const lo", 32'(o_data), 32'h01);
        check("mul_ff_ff const hi", 32'(o_data_hi), 32'hFE);
        check("mul_ff_ff const carry", 32'(o_carry), 32'd1);
`else
        check("mul illegal lo", 32'(o_data), 32'h00);
        check("mul illegal flags held", 32'({o_zero, o_carry, o_odd, o_neg, o_ovf}), 32'b00110);
`endif

        // DIV 100/7 with clk_en toggling, then done held while clk_en is low.
        do_op(4'd12, 8'h64, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, "div_100_7");
`ifdef ALU_SEQ_MULDIV_EN
        check("div_100_7 const lo", 32'(o_data), 32'h0E);
        check("div_100_7 const hi", 32'(o_data_hi), 32'h02);
`endif
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done held while clk_en low", 32'(o_done), 32'd1);
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("done clears after enable", 32'(o_done), 32'd0);

        do_op(4'd12, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "div_by_0");
`ifdef ALU_SEQ_MULDIV_EN
        check("div_by_0 const lo", 32'(o_data), 32'hFF);
        check("div_by_0 const hi", 32'(o_data_hi), 32'h05);
        check("div_by_0 const carry", 32'(o_carry), 32'd1);
`endif

        // Back-to-back launches from DONE.
        do_op(4'd0, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, "b2b add");
        do_op(4'd1, 8'h05, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, "b2b sub");
        do_op(4'd11, 8'h0C, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, "b2b mul");

        for (int i = 0; i < 250; i++) begin
            do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $sformatf("rand%0d", i));
        end

        // Make flags non-zero, then reset in the middle of a MUL.
        do_op(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, "pre-reset sub");
        clk_en = 1'b1; i_op = 4'd11; i_a = 8'hFF; i_t = 8'hFF; i_latch_flags = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrun reset busy", 32'(o_busy), 32'd0);
        check("midrun reset done", 32'(o_done), 32'd0);
        check("midrun reset lo", 32'(o_data), 32'd0);
        check("midrun reset hi", 32'(o_data_hi), 32'd0);
        check("midrun reset flags", 32'({o_zero, o_carry, o_odd, o_neg, o_ovf}), 32'd0);
        i_rst_n = 1'b1;
        m_z = 0; m_c = 0; m_o = 0; m_n = 0; m_v = 0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o_done) seen = 1'b1;
        end
        check("no done after midrun reset", 32'(seen), 32'd0);
        do_op(4'd2, 8'h40, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, "post-reset adc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
